// File: rtl/conv_ctrl_pkg.sv
// Shared types and width helpers for the conv-layer controller and its delay line.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_MAC    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } fsm_state_t;

  // A counter still needs one bit when its range collapses to a single value.
  function automatic int calc_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(input int max_width, input int max_height, input int max_ch_out);
    return calc_w(max_width) + calc_w(max_height) + calc_w(max_ch_out);
  endfunction

  typedef struct packed {
    logic wb;
    logic fin;
  } psum_tag_t;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-depth shift register, DEPTH cycles from din to dout, advances every cycle.
// No backpressure; synchronous reset clears every stage so nothing leaks out after reset.
module delay_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_controller_param.sv
// Conv-layer sequencer: weight loads then MAC beats per (ci,co); writeback/output PIPE_DEPTH cycles after last MAC beat.
// Host backpressure via valid/ready; ready only in LOAD_W and MAC, valid low freezes all counters.
module conv_controller_param
  import conv_ctrl_pkg::*;
#(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int MAX_WIDTH          = 64,
  parameter int MAX_HEIGHT         = 64,
  parameter int MAX_CH_IN          = 64,
  parameter int MAX_CH_OUT         = 32,
  parameter int BEATS              = 2,
  parameter int PIPE_DEPTH         = 5,
  localparam int X_W    = calc_w(MAX_WIDTH),
  localparam int Y_W    = calc_w(MAX_HEIGHT),
  localparam int CI_W   = calc_w(MAX_CH_IN),
  localparam int CO_W   = calc_w(MAX_CH_OUT),
  localparam int ADDR_W = addr_w(MAX_WIDTH, MAX_HEIGHT, MAX_CH_OUT)
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [X_W-1:0]                cfg_x_last,
  input  logic [Y_W-1:0]                cfg_y_last,
  input  logic [CI_W-1:0]               cfg_ci_last,
  input  logic [CO_W-1:0]               cfg_co_last,
  output logic                          running,
  output logic                          done,
  input  logic                          valid,
  output logic                          ready,
  output logic [BEATS-1:0]              write_w,
  output logic [BEATS-1:0]              write_a,
  output logic                          mac_valid,
  output logic                          mac_accumulate_with_0,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic                          output_valid,
  output logic [31:0]                   output_x,
  output logic [31:0]                   output_y,
  output logic [31:0]                   output_ch
);

  localparam int B_W = calc_w(BEATS);
  localparam int D_W = calc_w(PIPE_DEPTH);

  typedef struct packed {
    psum_tag_t       tag;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [CO_W-1:0] co;
  } wb_bundle_t;

  fsm_state_t      state;
  logic [B_W-1:0]  b;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [CO_W-1:0] co;
  logic [CI_W-1:0] ci;
  logic [D_W-1:0]  dcnt;

  logic [X_W-1:0]  x_last_q;
  logic [Y_W-1:0]  y_last_q;
  logic [CI_W-1:0] ci_last_q;
  logic [CO_W-1:0] co_last_q;

  logic beat, last_b, last_x, last_y, last_co, last_ci, mac_last;
  wb_bundle_t wb_in, wb_out;

  always_comb begin
    ready    = (state == ST_LOAD_W) || (state == ST_MAC);
    beat     = valid && ready;
    last_b   = (b == B_W'(BEATS - 1));
    last_x   = (x == x_last_q);
    last_y   = (y == y_last_q);
    last_co  = (co == co_last_q);
    last_ci  = (ci == ci_last_q);
    mac_last = beat && (state == ST_MAC) && last_b;
  end

  assign running               = (state != ST_IDLE);
  assign done                  = (state == ST_DONE);
  assign write_w               = (beat && state == ST_LOAD_W) ? (BEATS'(1) << b) : '0;
  assign write_a               = (beat && state == ST_MAC) ? (BEATS'(1) << b) : '0;
  assign mac_valid             = beat && (state == ST_MAC);
  assign mac_accumulate_with_0 = (state == ST_MAC) && (ci == '0);
  assign mem_re                = mac_last;
  assign mem_read_addr         = LOG2_OF_MEM_HEIGHT'({x, y, co});

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      b         <= '0;
      x         <= '0;
      y         <= '0;
      co        <= '0;
      ci        <= '0;
      dcnt      <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
      ci_last_q <= '0;
      co_last_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_last_q  <= cfg_x_last;
            y_last_q  <= cfg_y_last;
            ci_last_q <= cfg_ci_last;
            co_last_q <= cfg_co_last;
            b         <= '0;
            x         <= '0;
            y         <= '0;
            co        <= '0;
            ci        <= '0;
            state     <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (beat) begin
            if (last_b) begin
              b     <= '0;
              state <= ST_MAC;
            end else begin
              b <= b + 1'b1;
            end
          end
        end
        ST_MAC: begin
          if (beat) begin
            if (!last_b) begin
              b <= b + 1'b1;
            end else begin
              b <= '0;
              // y is innermost spatial loop; a full x/y sweep completes one (ci,co) pass.
              if (!last_y) begin
                y <= y + 1'b1;
              end else begin
                y <= '0;
                if (!last_x) begin
                  x <= x + 1'b1;
                end else begin
                  x <= '0;
                  if (!last_co) begin
                    co <= co + 1'b1;
                  end else begin
                    co <= '0;
                    ci <= last_ci ? '0 : ci + 1'b1;
                  end
                end
              end
              if (last_y && last_x) begin
                if (last_co && last_ci) begin
                  dcnt  <= '0;
                  state <= ST_DRAIN;
                end else begin
                  state <= ST_LOAD_W;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt == D_W'(PIPE_DEPTH - 1)) state <= ST_DONE;
          else                               dcnt  <= dcnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Coordinates are zeroed when no psum is launched so idle stages carry nothing.
  always_comb begin
    wb_in         = '0;
    wb_in.tag.wb  = mac_last && !last_ci;
    wb_in.tag.fin = mac_last && last_ci;
    if (mac_last) begin
      wb_in.x  = x;
      wb_in.y  = y;
      wb_in.co = co;
    end
  end

  delay_pipe #(
    .WIDTH($bits(wb_bundle_t)),
    .DEPTH(PIPE_DEPTH)
  ) u_delay (
    .clk   (clk),
    .rst_in(rst_in),
    .din   (wb_in),
    .dout  (wb_out)
  );

  assign mem_we         = wb_out.tag.wb;
  assign output_valid   = wb_out.tag.fin;
  assign mem_write_addr = LOG2_OF_MEM_HEIGHT'({wb_out.x, wb_out.y, wb_out.co});
  assign output_x       = 32'(wb_out.x);
  assign output_y       = 32'(wb_out.y);
  assign output_ch      = 32'(wb_out.co);

endmodule

// File: tb/tb_conv_controller_param.sv
// Self-checking bench: table of run configurations, loop-order beat model, scoreboard for delayed writebacks.
module tb_conv_controller_param;

  localparam int BEATS = 2;
  localparam int PD    = 5;
  localparam int X_W   = 6;
  localparam int Y_W   = 6;
  localparam int CI_W  = 6;
  localparam int CO_W  = 5;
  localparam int MW    = 20;

  logic            clk;
  logic            rst_in;
  logic            start;
  logic [X_W-1:0]  cfg_x_last;
  logic [Y_W-1:0]  cfg_y_last;
  logic [CI_W-1:0] cfg_ci_last;
  logic [CO_W-1:0] cfg_co_last;
  logic            running, done, valid, ready;
  logic [BEATS-1:0] write_w, write_a;
  logic            mac_valid, mac_accumulate_with_0, mem_re, mem_we, output_valid;
  logic [MW-1:0]   mem_read_addr, mem_write_addr;
  logic [31:0]     output_x, output_y, output_ch;

  conv_controller_param #(.BEATS(BEATS), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .cfg_x_last(cfg_x_last), .cfg_y_last(cfg_y_last),
    .cfg_ci_last(cfg_ci_last), .cfg_co_last(cfg_co_last),
    .running(running), .done(done), .valid(valid), .ready(ready),
    .write_w(write_w), .write_a(write_a), .mac_valid(mac_valid),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re), .mem_read_addr(mem_read_addr),
    .mem_we(mem_we), .mem_write_addr(mem_write_addr),
    .output_valid(output_valid), .output_x(output_x),
    .output_y(output_y), .output_ch(output_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] pack_addr(input int px, input int py, input int pco);
    return (64'(px) << (Y_W + CO_W)) | (64'(py) << CO_W) | 64'(pco);
  endfunction

  typedef struct {
    int due;
    int x;
    int y;
    int co;
    bit wb;
    bit fin;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  bit mon_en = 1'b0;
  int beat_cnt, ov_cnt, we_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid && ready) beat_cnt++;
      if (output_valid) ov_cnt++;
      if (mem_we) we_cnt++;
      if (mem_we || output_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_writeback", {mem_we, output_valid}, 2'b00);
        end else begin
          mon_e = sbq.pop_front();
          check("wb_cycle", cyc, mon_e.due);
          check("wb_flags", {mem_we, output_valid}, {mon_e.wb, mon_e.fin});
          check("output_x", output_x, mon_e.x);
          check("output_y", output_y, mon_e.y);
          check("output_ch", output_ch, mon_e.co);
          check("mem_write_addr", mem_write_addr, pack_addr(mon_e.x, mon_e.y, mon_e.co));
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        check("missing_writeback", 1'b0, 1'b1);
      end
    end
  end

  typedef struct {
    int xl;
    int yl;
    int cil;
    int col;
    int gap;
    bit glitch;
    int exp_beats;
    int exp_ov;
    int exp_we;
  } vec_t;
  vec_t tbl[5];

  task automatic drive_beat(input bit is_mac, input int b, input int ci, input int cil,
                            input int x, input int y, input int co,
                            input int gap_pct, input bit glitch);
    int gaps;
    gaps = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 2)) : 0;
    for (int g = 0; g < gaps; g++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (glitch) begin
        start       = 1'($urandom_range(0, 1));
        cfg_x_last  = X_W'($urandom_range(0, 63));
        cfg_y_last  = Y_W'($urandom_range(0, 63));
        cfg_ci_last = CI_W'($urandom_range(0, 63));
        cfg_co_last = CO_W'($urandom_range(0, 31));
      end
      @(negedge clk);
      check("gap_ready", ready, 1'b1);
      check("gap_strobes", {write_w, write_a, mac_valid, mem_re}, '0);
    end
    @(posedge clk); #1;
    valid = 1'b1;
    start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check("beat_ready", ready, 1'b1);
    if (!is_mac) begin
      check("load_write_w", write_w, 1 << b);
      check("load_other", {write_a, mac_valid, mem_re}, '0);
    end else begin
      check("mac_write_w", write_w, '0);
      check("mac_write_a", write_a, 1 << b);
      check("mac_valid", mac_valid, 1'b1);
      check("mac_acc0", mac_accumulate_with_0, (ci == 0));
      check("mem_re", mem_re, (b == BEATS - 1));
      if (b == BEATS - 1) begin
        check("mem_read_addr", mem_read_addr, pack_addr(x, y, co));
        sbq.push_back('{due: cyc + PD, x: x, y: y, co: co, wb: (ci != cil), fin: (ci == cil)});
      end
    end
  endtask

  task automatic run_cfg(input int idx);
    vec_t v;
    v = tbl[idx];
    beat_cnt = 0;
    ov_cnt   = 0;
    we_cnt   = 0;
    @(posedge clk); #1;
    cfg_x_last  = X_W'(v.xl);
    cfg_y_last  = Y_W'(v.yl);
    cfg_ci_last = CI_W'(v.cil);
    cfg_co_last = CO_W'(v.col);
    start = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("idle_running", running, 1'b0);
    check("idle_ready", ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    if (v.glitch) begin
      cfg_x_last  = X_W'(v.xl + 5);
      cfg_y_last  = Y_W'(v.yl + 7);
      cfg_ci_last = CI_W'(v.cil + 3);
      cfg_co_last = CO_W'(v.col + 2);
    end
    @(negedge clk);
    check("start_running", running, 1'b1);
    check("start_ready", ready, 1'b1);
    for (int ci = 0; ci <= v.cil; ci++)
      for (int co = 0; co <= v.col; co++) begin
        for (int b = 0; b < BEATS; b++)
          drive_beat(1'b0, b, ci, v.cil, 0, 0, co, v.gap, v.glitch);
        for (int x = 0; x <= v.xl; x++)
          for (int y = 0; y <= v.yl; y++)
            for (int b = 0; b < BEATS; b++)
              drive_beat(1'b1, b, ci, v.cil, x, y, co, v.gap, v.glitch);
      end
    for (int k = 1; k <= PD + 1; k++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      start = (k == PD + 1) && v.glitch;
      @(negedge clk);
      check("done_timing", done, (k == PD + 1));
      check("drain_running", running, 1'b1);
      check("drain_ready", ready, 1'b0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("end_running", running, 1'b0);
    check("end_done", done, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_restart", running, 1'b0);
    check("beat_count", beat_cnt, v.exp_beats);
    check("output_valid_count", ov_cnt, v.exp_ov);
    check("mem_we_count", we_cnt, v.exp_we);
    check("scoreboard_empty", sbq.size(), 0);
  endtask

  initial begin
    tbl[0] = '{xl: 0, yl: 0, cil: 0, col: 0, gap: 0,  glitch: 1'b0, exp_beats: 4,  exp_ov: 1,  exp_we: 0};
    tbl[1] = '{xl: 0, yl: 0, cil: 2, col: 0, gap: 0,  glitch: 1'b0, exp_beats: 12, exp_ov: 1,  exp_we: 2};
    tbl[2] = '{xl: 3, yl: 3, cil: 0, col: 1, gap: 0,  glitch: 1'b0, exp_beats: 68, exp_ov: 32, exp_we: 0};
    tbl[3] = '{xl: 0, yl: 0, cil: 0, col: 0, gap: 50, glitch: 1'b0, exp_beats: 4,  exp_ov: 1,  exp_we: 0};
    tbl[4] = '{xl: 1, yl: 2, cil: 1, col: 1, gap: 30, glitch: 1'b1, exp_beats: 56, exp_ov: 12, exp_we: 12};

    rst_in = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    cfg_x_last = '0;
    cfg_y_last = '0;
    cfg_ci_last = '0;
    cfg_co_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_strobes", {write_w, write_a, mac_valid, mac_accumulate_with_0, mem_re, mem_we, output_valid}, '0);
    check("rst_addrs", {mem_read_addr, mem_write_addr}, '0);
    check("rst_coords", {output_x, output_y, output_ch}, '0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_cfg(i);

    // Abort mid-MAC with two psums still travelling down the delay line.
    @(posedge clk); #1;
    cfg_x_last = 6'd1;
    cfg_y_last = 6'd1;
    cfg_ci_last = 6'd2;
    cfg_co_last = 5'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < BEATS; b++) drive_beat(1'b0, b, 0, 2, 0, 0, 0, 0, 1'b0);
    for (int y = 0; y < 2; y++)
      for (int b = 0; b < BEATS; b++) drive_beat(1'b1, b, 0, 2, 0, y, 0, 0, 1'b0);
    @(posedge clk); #1;
    rst_in = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    check("abort_running", running, 1'b0);
    check("abort_ready", ready, 1'b0);
    for (int k = 0; k < PD + 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_no_residual", {mem_we, output_valid, mac_valid}, '0);
      check("abort_idle", running, 1'b0);
    end
    valid = 1'b0;

    run_cfg(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
